// File: rtl/io_responder.sv
// rtl/io_responder.sv - CPU IO-window byte responder with TX FIFO, RX holding register, halt flag and cycle counter

module io_responder #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       en_in,
  input  logic       r_nw_in,
  input  logic [2:0] a_in,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic [7:0] tx_byte_out,
  output logic       tx_valid_out,
  input  logic       tx_ready_in,
  input  logic [7:0] rx_byte_in,
  input  logic       rx_valid_in,
  output logic       rx_ready_out,
  output logic       halt_out,
  output logic       tx_full_out
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   fifo_cnt_q, fifo_cnt_d;
  logic               ovf_q, ovf_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic               halt_q, halt_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        snap_q, snap_d;
  logic [7:0]         d_out_q, d_out_d;

  logic rd_acc, wr_acc, push_req, push, pop, capture;
  logic [7:0] rdata;

  assign tx_valid_out = (fifo_cnt_q != '0);
  assign tx_full_out  = (fifo_cnt_q == FULL_CNT);
  assign tx_byte_out  = mem_q[rd_ptr_q];
  assign rx_ready_out = ~rx_valid_q;
  assign halt_out     = halt_q;
  assign d_out        = d_out_q;

  // Access decode, read-data mux and next-state for all control registers
  always_comb begin
    rd_acc   = en_in & r_nw_in;
    wr_acc   = en_in & ~r_nw_in;
    pop      = tx_valid_out & tx_ready_in;
    push_req = wr_acc && (a_in == 3'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push     = push_req && (!tx_full_out || pop);
    capture  = rx_valid_in & ~rx_valid_q;

    case (a_in)
      3'd0:    rdata = rx_valid_q ? rx_byte_q : 8'h00;
      3'd1:    rdata = {5'b0, ovf_q, rx_valid_q, tx_full_out};
      3'd4:    rdata = cnt_q[7:0];
      3'd5:    rdata = snap_q[15:8];
      3'd6:    rdata = snap_q[23:16];
      3'd7:    rdata = snap_q[31:24];
      default: rdata = 8'h00;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    ovf_d      = ovf_q | (push_req & tx_full_out & ~pop);

    // A capture only happens into an empty register, so a same-cycle read of
    // offset 0 sees it empty and cannot clear the freshly captured byte.
    rx_valid_d = rx_valid_q;
    rx_byte_d  = rx_byte_q;
    if (rd_acc && (a_in == 3'd0) && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end else if (capture) begin
      rx_valid_d = 1'b1;
      rx_byte_d  = rx_byte_in;
    end

    halt_d  = halt_q | (wr_acc && (a_in == 3'd4));
    cnt_d   = halt_q ? cnt_q : cnt_q + 32'd1;
    snap_d  = (rd_acc && (a_in == 3'd4)) ? cnt_q : snap_q;
    d_out_d = rd_acc ? rdata : d_out_q;
  end

  // Control and datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      ovf_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      halt_q     <= 1'b0;
      cnt_q      <= 32'd0;
      snap_q     <= 32'd0;
      d_out_q    <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      ovf_q      <= ovf_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      halt_q     <= halt_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      d_out_q    <= d_out_d;
    end
  end

  // TX FIFO storage; cleared on reset so the head byte reads 0 when empty
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (push) begin
      mem_q[wr_ptr_q] <= d_in;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - scoreboard testbench for io_responder

module tb_io_responder;
  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       en_in = 1'b0;
  logic       r_nw_in = 1'b0;
  logic [2:0] a_in = 3'd0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic [7:0] tx_byte_out;
  logic       tx_valid_out;
  logic       tx_ready_in = 1'b0;
  logic [7:0] rx_byte_in = 8'h00;
  logic       rx_valid_in = 1'b0;
  logic       rx_ready_out;
  logic       halt_out;
  logic       tx_full_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] rd_q[$];
  logic [7:0] tx_q[$];
  logic       rd_flag;

  io_responder #(.FIFO_AW(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .en_in(en_in), .r_nw_in(r_nw_in),
    .a_in(a_in), .d_in(d_in), .d_out(d_out), .tx_byte_out(tx_byte_out),
    .tx_valid_out(tx_valid_out), .tx_ready_in(tx_ready_in),
    .rx_byte_in(rx_byte_in), .rx_valid_in(rx_valid_in),
    .rx_ready_out(rx_ready_out), .halt_out(halt_out), .tx_full_out(tx_full_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Remember which edges carried a read so the monitor knows when d_out is due
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rd_flag <= 1'b0;
    else           rd_flag <= en_in & r_nw_in;
  end

  // Monitor: compare read data and consumed TX bytes against the queues
  always @(negedge clk_in) begin
    if (rd_flag) begin
      if (rd_q.size() == 0) chk("rd_unexpected", 32'(d_out), 32'hFFFF_FFFF);
      else                  chk("rd_data", 32'(d_out), 32'(rd_q.pop_front()));
    end
    if (rst_n_in && tx_valid_out && tx_ready_in) begin
      if (tx_q.size() == 0) chk("tx_unexpected", 32'(tx_byte_out), 32'hFFFF_FFFF);
      else                  chk("tx_byte", 32'(tx_byte_out), 32'(tx_q.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    en_in = 1'b1; r_nw_in = 1'b0; a_in = a; d_in = d;
    step();
    en_in = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [7:0] exp);
    en_in = 1'b1; r_nw_in = 1'b1; a_in = a;
    rd_q.push_back(exp);
    step();
    en_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    chk("rst_d_out", 32'(d_out), 32'h00);
    chk("rst_tx_valid", 32'(tx_valid_out), 32'h0);
    chk("rst_tx_byte", 32'(tx_byte_out), 32'h00);
    chk("rst_rx_ready", 32'(rx_ready_out), 32'h1);
    chk("rst_halt", 32'(halt_out), 32'h0);
    chk("rst_tx_full", 32'(tx_full_out), 32'h0);
    step();
    rst_n_in = 1'b1;
    step();

    // Asynchronous reset mid-stream with five queued bytes
    rx_byte_in = 8'h77; rx_valid_in = 1'b1;
    step();
    rx_valid_in = 1'b0;
    do_read(3'd0, 8'h77);
    for (int i = 0; i < 5; i++) begin
      do_write(3'd0, 8'(8'h60 + i));
      tx_q.push_back(8'(8'h60 + i));
    end
    do_write(3'd4, 8'h01);
    chk("pre_rst_halt", 32'(halt_out), 32'h1);
    chk("pre_rst_tx_valid", 32'(tx_valid_out), 32'h1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_tx_valid", 32'(tx_valid_out), 32'h0);
    chk("async_d_out", 32'(d_out), 32'h00);
    chk("async_halt", 32'(halt_out), 32'h0);
    chk("async_tx_full", 32'(tx_full_out), 32'h0);
    chk("async_tx_byte", 32'(tx_byte_out), 32'h00);
    tx_q.delete();
    step();
    rst_n_in = 1'b1;
    step();

    // TX ordering, no fall-through
    chk("tx_empty_after_rst", 32'(tx_valid_out), 32'h0);
    do_write(3'd0, 8'h41); tx_q.push_back(8'h41);
    chk("tx_valid_next_cycle", 32'(tx_valid_out), 32'h1);
    do_write(3'd0, 8'h42); tx_q.push_back(8'h42);
    do_write(3'd0, 8'h43); tx_q.push_back(8'h43);
    tx_ready_in = 1'b1;
    repeat (3) step();
    tx_ready_in = 1'b0;
    chk("tx_drained3", 32'(tx_valid_out), 32'h0);
    chk("tx_q_empty3", 32'(tx_q.size()), 32'd0);

    // Full, overflow, push+pop while full
    for (int i = 0; i < 16; i++) begin
      do_write(3'd0, 8'(8'h10 + i));
      tx_q.push_back(8'(8'h10 + i));
    end
    chk("full_after16", 32'(tx_full_out), 32'h1);
    do_write(3'd0, 8'h99);
    do_read(3'd1, 8'h05);
    tx_ready_in = 1'b1;
    do_write(3'd0, 8'hAA); tx_q.push_back(8'hAA);
    tx_ready_in = 1'b0;
    chk("full_after_pushpop", 32'(tx_full_out), 32'h1);
    do_read(3'd1, 8'h05);
    tx_ready_in = 1'b1;
    repeat (16) step();
    tx_ready_in = 1'b0;
    chk("drained16_valid", 32'(tx_valid_out), 32'h0);
    chk("drained16_full", 32'(tx_full_out), 32'h0);
    chk("drained16_q", 32'(tx_q.size()), 32'd0);
    do_read(3'd1, 8'h04);

    // RX holding register
    rx_byte_in = 8'h5A; rx_valid_in = 1'b1;
    step();
    rx_valid_in = 1'b0;
    chk("rx_ready_busy", 32'(rx_ready_out), 32'h0);
    do_read(3'd0, 8'h5A);
    chk("rx_ready_free", 32'(rx_ready_out), 32'h1);
    do_read(3'd0, 8'h00);
    rx_byte_in = 8'h33; rx_valid_in = 1'b1;
    do_read(3'd0, 8'h00);
    rx_valid_in = 1'b0;
    chk("rx_same_cycle_kept", 32'(rx_ready_out), 32'h0);
    do_read(3'd0, 8'h33);

    // Counter snapshot
    @(negedge clk_in);
    force dut.cnt_q = 32'h1234_5678;
    release dut.cnt_q;
    do_read(3'd4, 8'h78);
    do_read(3'd5, 8'h56);
    do_read(3'd6, 8'h34);
    do_read(3'd7, 8'h12);

    // Wrap, halt freeze, en_in=0 holds d_out
    @(negedge clk_in);
    force dut.cnt_q = 32'hFFFF_FFFF;
    release dut.cnt_q;
    do_read(3'd4, 8'hFF);
    do_read(3'd4, 8'h00);
    do_read(3'd7, 8'h00);
    do_write(3'd4, 8'h5C);
    chk("halt_set", 32'(halt_out), 32'h1);
    repeat (3) step();
    do_read(3'd5, 8'h00);
    do_read(3'd4, 8'h03);
    r_nw_in = 1'b1; a_in = 3'd1; en_in = 1'b0;
    repeat (2) step();
    chk("en0_hold", 32'(d_out), 32'h03);
    chk("halt_sticky", 32'(halt_out), 32'h1);

    step();
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
